// File: rtl/btn_cmd_conditioner.sv
// Two-channel push-button conditioner: 2-FF synchronizer and debounce FSM per
// button, then a registered arbiter that turns confirmed presses into one-cycle commands.

module btn_cmd_channel #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int CNT_W           = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic fire,
  output logic held
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ARMING    = 2'b01,
    ST_HELD      = 2'b10,
    ST_RELEASING = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1_r;
  logic             sync_2_r;
  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             fire_s;
  logic             release_s;
  logic             fire_r;
  logic             held_r;

  // Two-flop synchronizer; only sync_2_r is ever looked at by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1_r <= 1'b0;
      sync_2_r <= 1'b0;
    end else begin
      sync_1_r <= btn_raw;
      sync_2_r <= sync_1_r;
    end
  end

  // Debounce next-state logic: the IDLE/HELD entry sample counts as the first of the run.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    fire_s    = 1'b0;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sync_2_r) begin
          state_s = ST_ARMING;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARMING: begin
        if (!sync_2_r) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_HELD;
          fire_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!sync_2_r) begin
          state_s = ST_RELEASING;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = ST_HELD;
        end
      end
      ST_RELEASING: begin
        if (sync_2_r) begin
          state_s = ST_HELD;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = ST_IDLE;
          release_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered fire/held; held rises one edge after fire_r,
  // aligned with the arbitrated command pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      fire_r  <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      fire_r  <= fire_s;
      if (fire_r) begin
        held_r <= 1'b1;
      end else if (release_s) begin
        held_r <= 1'b0;
      end else begin
        held_r <= held_r;
      end
    end
  end

  assign fire = fire_r;
  assign held = held_r;

endmodule

module btn_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int CNT_W           = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic cmd_a,
  output logic cmd_b,
  output logic held_a,
  output logic held_b,
  output logic collision
);

  logic fire_a_s;
  logic fire_b_s;
  logic held_a_s;
  logic held_b_s;
  logic cmd_a_r;
  logic cmd_b_r;
  logic collision_r;

  btn_cmd_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_a_raw),
    .fire   (fire_a_s),
    .held   (held_a_s)
  );

  btn_cmd_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_b_raw),
    .fire   (fire_b_s),
    .held   (held_b_s)
  );

  // Arbiter: a same-edge double acceptance becomes collision, never {cmd_a,cmd_b}=11.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_a_r     <= 1'b0;
      cmd_b_r     <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      cmd_a_r     <= fire_a_s & ~fire_b_s;
      cmd_b_r     <= fire_b_s & ~fire_a_s;
      collision_r <= fire_a_s & fire_b_s;
    end
  end

  assign cmd_a     = cmd_a_r;
  assign cmd_b     = cmd_b_r;
  assign collision = collision_r;
  assign held_a    = held_a_s;
  assign held_b    = held_b_s;

endmodule

// Output-exclusivity checker, kept apart from the datapath.
module btn_cmd_conditioner_chk (
  input logic clk,
  input logic reset,
  input logic cmd_a,
  input logic cmd_b,
  input logic collision
);

  a_cmd_exclusive: assert property (@(posedge clk) disable iff (reset) !(cmd_a && cmd_b));
  a_collision_alone: assert property (@(posedge clk) disable iff (reset)
                                      !(collision && (cmd_a || cmd_b)));

endmodule

// File: tb/tb_btn_cmd_conditioner.sv
// Directed bench for btn_cmd_conditioner with DEBOUNCE_CYCLES=4; expected pulses
// are queued with their edge number when stimulus is driven and matched by a monitor.

module tb_btn_cmd_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_a;
  logic btn_b;
  logic cmd_a;
  logic cmd_b;
  logic held_a;
  logic held_b;
  logic collision;

  int edge_n = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         edge_i;
    logic [2:0] val;
  } exp_t;

  exp_t sb_q[$];

  btn_cmd_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (14)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_a_raw(btn_a),
    .btn_b_raw(btn_b),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .held_a   (held_a),
    .held_b   (held_b),
    .collision(collision)
  );

  btn_cmd_conditioner_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .collision(collision)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int e, input logic [2:0] v);
    exp_t x;
    x.edge_i = e;
    x.val    = v;
    sb_q.push_back(x);
  endtask

  // Returns at the negedge that follows posedge number n.
  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  // Pulse monitor: {cmd_a,cmd_b,collision} must match the queue head on its edge.
  always @(negedge clk) begin
    exp_t x;
    if (reset === 1'b0 && (cmd_a || cmd_b || collision)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, cmd_a, cmd_b, collision}, 32'd0);
      end else begin
        x = sb_q.pop_front();
        check("pulse_edge", edge_n, x.edge_i);
        check("pulse_val", {29'd0, cmd_a, cmd_b, collision}, {29'd0, x.val});
      end
    end else if (sb_q.size() > 0 && sb_q[0].edge_i < edge_n) begin
      x = sb_q.pop_front();
      check("missed_pulse_edge", edge_n, x.edge_i);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m, s, c, t, g, b, r;
    logic pat [9];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    btn_a = 1'b0;
    btn_b = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_a", cmd_a, 1'b0);
    check("rst_cmd_b", cmd_b, 1'b0);
    check("rst_held_a", held_a, 1'b0);
    check("rst_held_b", held_b, 1'b0);
    check("rst_collision", collision, 1'b0);
    reset = 1'b0;

    // Clean press: raw high sampled at edge k, held 20 cycles
    @(negedge clk);
    k = edge_n + 1;
    btn_a = 1'b1;
    push(k + D + 2, 3'b100);
    wait_edge(k + D + 1);
    check("clean_held_a_before", held_a, 1'b0);
    wait_edge(k + D + 2);
    check("clean_held_a_rise", held_a, 1'b1);
    wait_edge(k + 19);
    btn_a = 1'b0;
    m = k + 20;
    wait_edge(m + D);
    check("clean_held_a_still", held_a, 1'b1);
    wait_edge(m + D + 1);
    check("clean_held_a_fall", held_a, 1'b0);
    wait_edge(m + 10);

    // Bounce: final 4-high run starts at s+5
    s = edge_n + 1;
    push(s + 5 + D + 2, 3'b100);
    for (int i = 0; i < 9; i++) begin
      wait_edge(s + i - 1);
      btn_a = pat[i];
    end
    wait_edge(s + 11);
    check("bounce_held_a", held_a, 1'b1);
    wait_edge(s + 14);
    btn_a = 1'b0;
    wait_edge(s + 24);
    check("bounce_released", held_a, 1'b0);

    // Collision: both rise on the same edge
    c = edge_n + 1;
    btn_a = 1'b1;
    btn_b = 1'b1;
    push(c + D + 2, 3'b001);
    wait_edge(c + D + 2);
    check("coll_held_a", held_a, 1'b1);
    check("coll_held_b", held_b, 1'b1);
    wait_edge(c + 9);
    btn_a = 1'b0;
    btn_b = 1'b0;
    wait_edge(c + 20);

    // Staggered: B one cycle after A
    t = edge_n + 1;
    btn_a = 1'b1;
    push(t + D + 2, 3'b100);
    push(t + D + 3, 3'b010);
    wait_edge(t);
    btn_b = 1'b1;
    wait_edge(t + 10);
    check("stag_held_a", held_a, 1'b1);
    check("stag_held_b", held_b, 1'b1);
    btn_a = 1'b0;
    btn_b = 1'b0;
    wait_edge(t + 22);

    // Release glitch: low sampled at g+10, re-pressed at g+12
    g = edge_n + 1;
    btn_a = 1'b1;
    push(g + D + 2, 3'b100);
    wait_edge(g + 9);
    btn_a = 1'b0;
    wait_edge(g + 11);
    btn_a = 1'b1;
    for (int e = g + 11; e <= g + 20; e++) begin
      wait_edge(e);
      check("glitch_held_a", held_a, 1'b1);
    end
    btn_a = 1'b0;
    wait_edge(g + 27);
    check("glitch_held_a_fall", held_a, 1'b0);
    wait_edge(g + 32);

    // Asynchronous reset with B held and A in ARMING
    b = edge_n + 1;
    btn_b = 1'b1;
    push(b + D + 2, 3'b010);
    wait_edge(b + 8);
    check("rst2_held_b_pre", held_b, 1'b1);
    btn_a = 1'b1;
    wait_edge(b + 12);
    #2;
    reset = 1'b1;
    #1;
    check("rst2_held_b", held_b, 1'b0);
    check("rst2_held_a", held_a, 1'b0);
    check("rst2_cmd_a", cmd_a, 1'b0);
    check("rst2_cmd_b", cmd_b, 1'b0);
    check("rst2_collision", collision, 1'b0);
    btn_a = 1'b0;
    btn_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    r = edge_n + 1;
    wait_edge(r + 8);
    check("rst2_quiet_held_a", held_a, 1'b0);
    check("rst2_quiet_held_b", held_b, 1'b0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_cmd_conditioner.md
# btn_cmd_conditioner

Upstream input-conditioning stage for the two-input command FSMs in this codebase. It takes two raw, asynchronous, bouncing push-button levels and synchronizes and debounces each one. Each confirmed press becomes a single-clock command pulse, driven onto the FSM's `inA`/`inB` inputs. Simultaneous confirmed presses are rejected, so the FSM never sees the ambiguous `{1,1}` code from this block.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 12000: consecutive stable synchronized samples required to accept a press or release. Legal range is 2 to 2^CNT_W−1.
- `CNT_W`, default 14: width of each debounce counter.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `btn_a_raw`, input, 1: raw button A level, asynchronous to `clk`, active-high.
- `btn_b_raw`, input, 1: raw button B level, asynchronous, active-high.
- `cmd_a`, output, 1: one-cycle pulse on an accepted A press; drives the FSM's `inA`.
- `cmd_b`, output, 1: one-cycle pulse on an accepted B press; drives the FSM's `inB`.
- `held_a`, output, 1: debounced A level, high in HELD or RELEASING.
- `held_b`, output, 1: debounced B level.
- `collision`, output, 1: one-cycle pulse when A and B are accepted on the same edge.

Reset is `reset`: asynchronous, active-high. Clock is `clk`.

## Operation
- Each channel has its own 2-FF synchronizer. `sync_x` is the second flop.
- Each channel has an identical 4-state FSM with counter `cnt`:
  - IDLE:
    - `sync_x=1`: go to ARMING, `cnt<=1`.
    - otherwise stay.
  - ARMING:
    - `sync_x=0`: go to IDLE (bounce rejected).
    - `sync_x=1` and `cnt==DEBOUNCE_CYCLES−1`: go to HELD and raise `fire_x`.
    - otherwise `cnt<=cnt+1`.
  - HELD:
    - `sync_x=0`: go to RELEASING, `cnt<=1`.
    - otherwise stay.
  - RELEASING:
    - `sync_x=1`: go back to HELD, with no new pulse.
    - `sync_x=0` and `cnt==DEBOUNCE_CYCLES−1`: go to IDLE.
    - otherwise `cnt<=cnt+1`.
- Net rule: a press is accepted after exactly `DEBOUNCE_CYCLES` consecutive high `sync_x` samples. A release is accepted after the same number of consecutive low samples.
- A new pulse requires a full return to IDLE first. Holding a button never repeats the pulse.
- Output arbitration is a registered stage:
  - `cmd_a <= fire_a & ~fire_b`
  - `cmd_b <= fire_b & ~fire_a`
  - `collision <= fire_a & fire_b`
- When both fire, both channels still enter HELD, so neither pulse is re-issued later.
- `cmd_a` and `cmd_b` are never high in the same cycle.
- Illegal FSM encodings recover to IDLE on the next edge.

## Timing
- Reset values: every output 0, both FSMs IDLE, counters 0, synchronizer flops 0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- A button still held when reset is released is re-qualified from IDLE. It produces exactly one pulse, `DEBOUNCE_CYCLES+2` edges after release.
- Press latency: raw high sampled at edge k gives `cmd_x` high for exactly the one cycle following edge k+DEBOUNCE_CYCLES+2.
- Pulse width is always exactly 1 clock. `held_x` rises on the same edge as `cmd_x`.
- Release latency: `held_x` falls `DEBOUNCE_CYCLES+1` edges after raw low is sampled, given an uninterrupted low.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never produces a pulse.
- Fire edges within `DEBOUNCE_CYCLES` of each other but not on the same edge produce two separate pulses, in acceptance order.
- Counter never wraps: the maximum value reached is `DEBOUNCE_CYCLES−1`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset:** assert `reset` asynchronously mid-cycle while A is in ARMING. All outputs go 0 immediately, and no `cmd_a` fires for 6 edges after release unless A is high.
- **Clean press:** A high at edge 10, held for 20 cycles. `cmd_a` high only in the cycle after edge 16. `held_a` high from edge 16 until 5 edges after A falls. `cmd_b`=0 throughout.
- **Bounce:** A toggles 1,0,1,1,0,1,1,1,1. Exactly one `cmd_a` pulse, 6 edges after the start of the final 4-high run.
- **Collision:** A and B rise on the same edge and are held. `collision`=1 for one cycle, `cmd_a`=`cmd_b`=0 throughout, and both `held` outputs go high.
- **Staggered:** B rises 1 cycle after A. `cmd_a` pulses, then `cmd_b` pulses exactly one cycle later, never together.
- **Release glitch:** release A, re-press 2 cycles later. `held_a` stays 1 and no second `cmd_a` fires.
